// File: rtl/weights_loader.sv
// weights_loader: fetches one input channel's kernel-weight block from weight SRAM into a flat bank for the SA.
// Define WEIGHTS_DBUF_EN for a double-buffered bank that keeps the previous channel visible during a fetch.
module weights_loader #(
    parameter int ADR_W       = 16,
    parameter int SRAM_W      = 32,
    parameter int W_BITS      = 8,
    parameter int K_ELEMS     = 9,
    parameter int MAX_KERNELS = 32,
    parameter int RD_LAT      = 1,
    parameter int CH_W        = 7,
    localparam int N_W        = $clog2(MAX_KERNELS + 1),
    localparam int NUM_W      = K_ELEMS * MAX_KERNELS
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [CH_W-1:0]         i_channel,
    input  logic [N_W-1:0]          i_num_kernels,
    input  logic [ADR_W-1:0]        i_base_addr,
    output logic [ADR_W-1:0]        o_sram_addr,
    output logic                    o_sram_rden,
    input  logic [SRAM_W-1:0]       i_sram_data,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    output logic                    o_weights_valid,
    output logic [NUM_W*W_BITS-1:0] o_weights
);
    localparam int BPW     = SRAM_W / W_BITS;
    localparam int WPC_MAX = (NUM_W + BPW - 1) / BPW;
    localparam int CNT_W   = $clog2(WPC_MAX + 1);
    localparam int NB_W    = $clog2(NUM_W + BPW);
    localparam int BANK_W  = NUM_W * W_BITS;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d, loaded_ch_q, loaded_ch_d;
    logic [N_W-1:0]    n_q, n_d, loaded_n_q, loaded_n_d;
    logic [CNT_W-1:0]  wpc_q, wpc_d, iss_cnt_q, iss_cnt_d, cap_cnt_q, cap_cnt_d;
    logic [ADR_W-1:0]  addr_q, addr_d;
    logic              rden_q, rden_d, done_q, done_d, err_q, err_d, valid_q, valid_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [NB_W-1:0]   req_nb, cur_nb;
    logic [CNT_W-1:0]  req_wpc;
    logic [ADR_W-1:0]  req_first;
    logic              req_bad, req_hit, cap_fire;
    int                idx;

`ifdef WEIGHTS_DBUF_EN
    logic [BANK_W-1:0] act_q, act_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            act_q <= '0;
        end else begin
            act_q <= act_d;
        end
    end

    assign o_weights = act_q;
`else
    assign o_weights = bank_q;
`endif

    assign o_sram_addr     = addr_q;
    assign o_sram_rden     = rden_q;
    assign o_busy          = (state_q != S_IDLE);
    assign o_done          = done_q;
    assign o_err           = err_q;
    assign o_weights_valid = valid_q;

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        n_d         = n_q;
        wpc_d       = wpc_q;
        iss_cnt_d   = iss_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        addr_d      = addr_q;
        rden_d      = rden_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        valid_d     = valid_q;
        loaded_ch_d = loaded_ch_q;
        loaded_n_d  = loaded_n_q;
        bank_d      = bank_q;
`ifdef WEIGHTS_DBUF_EN
        act_d       = act_q;
`endif
        idx         = 0;
        // Shift register marks the cycle each issued word appears on i_sram_data.
        vld_d       = RD_LAT'({vld_q, rden_q});
        cap_fire    = vld_q[RD_LAT-1];
        cur_nb      = NB_W'(K_ELEMS) * NB_W'(n_q);
        req_nb      = NB_W'(K_ELEMS) * NB_W'(i_num_kernels);
        req_wpc     = CNT_W'((req_nb + NB_W'(BPW - 1)) / NB_W'(BPW));
        req_first   = i_base_addr + ADR_W'(i_channel) * ADR_W'(req_wpc);
        req_bad     = (i_num_kernels == '0) || (i_num_kernels > N_W'(MAX_KERNELS));
        req_hit     = valid_q && (i_channel == loaded_ch_q) && (i_num_kernels == loaded_n_q);

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else if (req_hit) begin
                        done_d = 1'b1;
                    end else begin
                        ch_d      = i_channel;
                        n_d       = i_num_kernels;
                        wpc_d     = req_wpc;
                        addr_d    = req_first;
                        rden_d    = 1'b1;
                        iss_cnt_d = CNT_W'(1);
                        cap_cnt_d = '0;
                        bank_d    = '0;
`ifdef WEIGHTS_DBUF_EN
                        valid_d   = valid_q;
`else
                        valid_d   = 1'b0;
`endif
                        state_d   = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (iss_cnt_q == wpc_q) begin
                    rden_d  = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d    = addr_q + ADR_W'(1);
                    iss_cnt_d = iss_cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_DRAIN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Unpack a returned word; bytes past the channel's last weight stay zero.
        if (cap_fire) begin
            for (int b = 0; b < BPW; b++) begin
                idx = int'(cap_cnt_q) * BPW + b;
                if (idx < int'(cur_nb) && idx < NUM_W) begin
                    bank_d[idx*W_BITS +: W_BITS] = i_sram_data[b*W_BITS +: W_BITS];
                end
            end
            cap_cnt_d = cap_cnt_q + CNT_W'(1);
            if (cap_cnt_q == wpc_q - CNT_W'(1)) begin
                done_d      = 1'b1;
                valid_d     = 1'b1;
                loaded_ch_d = ch_q;
                loaded_n_d  = n_q;
                state_d     = S_IDLE;
`ifdef WEIGHTS_DBUF_EN
                act_d       = bank_d;
`endif
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            n_q         <= '0;
            wpc_q       <= '0;
            iss_cnt_q   <= '0;
            cap_cnt_q   <= '0;
            addr_q      <= '0;
            rden_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
            loaded_ch_q <= '0;
            loaded_n_q  <= '0;
            vld_q       <= '0;
            bank_q      <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            n_q         <= n_d;
            wpc_q       <= wpc_d;
            iss_cnt_q   <= iss_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            addr_q      <= addr_d;
            rden_q      <= rden_d;
            done_q      <= done_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
            loaded_ch_q <= loaded_ch_d;
            loaded_n_q  <= loaded_n_d;
            vld_q       <= vld_d;
            bank_q      <= bank_d;
        end
    end
endmodule

// File: tb/tb_weights_loader.sv
// tb_weights_loader: directed and random fetch requests checked against a behavioural model of the weight loader.
// The model derives addresses, latency and bank contents directly from the block layout rules.
module tb_weights_loader;
    localparam int ADR_W       = 16;
    localparam int SRAM_W      = 32;
    localparam int W_BITS      = 8;
    localparam int K_ELEMS     = 9;
    localparam int MAX_KERNELS = 32;
    localparam int RD_LAT      = 3;
    localparam int CH_W        = 7;
    localparam int N_W         = $clog2(MAX_KERNELS + 1);
    localparam int NUM_W       = K_ELEMS * MAX_KERNELS;
    localparam int BPW         = SRAM_W / W_BITS;
    localparam int TIMEOUT     = 300;
`ifdef WEIGHTS_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic                    i_clk;
    logic                    i_rst;
    logic                    i_start;
    logic [CH_W-1:0]         i_channel;
    logic [N_W-1:0]          i_num_kernels;
    logic [ADR_W-1:0]        i_base_addr;
    logic [ADR_W-1:0]        o_sram_addr;
    logic                    o_sram_rden;
    logic [SRAM_W-1:0]       i_sram_data;
    logic                    o_busy;
    logic                    o_done;
    logic                    o_err;
    logic                    o_weights_valid;
    logic [NUM_W*W_BITS-1:0] o_weights;

    weights_loader #(
        .ADR_W(ADR_W), .SRAM_W(SRAM_W), .W_BITS(W_BITS), .K_ELEMS(K_ELEMS),
        .MAX_KERNELS(MAX_KERNELS), .RD_LAT(RD_LAT), .CH_W(CH_W)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_channel(i_channel),
        .i_num_kernels(i_num_kernels), .i_base_addr(i_base_addr),
        .o_sram_addr(o_sram_addr), .o_sram_rden(o_sram_rden), .i_sram_data(i_sram_data),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_weights_valid(o_weights_valid), .o_weights(o_weights)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int doneCnt = 0;
    int errCnt = 0;
    int expDone = 0;
    int expErr = 0;
    logic [31:0] seed;
    logic [ADR_W-1:0] rdQ [$];
    logic [7:0] mdlBank [NUM_W];
    bit mdlValid;
    int mdlCh;
    int mdlN;
    logic [ADR_W-1:0] apipe [RD_LAT];
    logic [RD_LAT-1:0] vpipe;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [31:0] sramWord(input logic [ADR_W-1:0] a, input logic [31:0] s);
        return (32'(a) * 32'h9E37_79B1) ^ s;
    endfunction

    // SRAM with RD_LAT-cycle read pipeline; junk is driven whenever no read is returning.
    always @(posedge i_clk) begin
        apipe[0] <= o_sram_addr;
        vpipe[0] <= o_sram_rden;
        for (int k = 1; k < RD_LAT; k++) begin
            apipe[k] <= apipe[k-1];
            vpipe[k] <= vpipe[k-1];
        end
    end
    assign i_sram_data = vpipe[RD_LAT-1] ? sramWord(apipe[RD_LAT-1], seed) : 32'hDEAD_BEEF;

    always @(negedge i_clk) begin
        if (o_sram_rden) rdQ.push_back(o_sram_addr);
        if (o_done) doneCnt <= doneCnt + 1;
        if (o_err) errCnt <= errCnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int countBad(input bit useZero);
        int bad = 0;
        logic [7:0] got;
        logic [7:0] want;
        for (int i = 0; i < NUM_W; i++) begin
            got  = o_weights[i*W_BITS +: W_BITS];
            want = useZero ? 8'h00 : mdlBank[i];
            if (got !== want) bad++;
        end
        return bad;
    endfunction

    task automatic applyStimulus(input int ch, input int n, input int base, input bit inject);
        logic [7:0] newBank [NUM_W];
        logic [31:0] word;
        bit isErr, isHit, isMiss;
        int wpc, first, t0, waited, badAddr;
        isErr  = (n == 0) || (n > MAX_KERNELS);
        isHit  = !isErr && mdlValid && (ch == mdlCh) && (n == mdlN);
        isMiss = !isErr && !isHit;
        wpc    = (K_ELEMS * n + BPW - 1) / BPW;
        first  = (base + ch * wpc) % (1 << ADR_W);
        for (int i = 0; i < NUM_W; i++) begin
            word = sramWord(ADR_W'(first + i / BPW), seed);
            newBank[i] = (i < K_ELEMS * n) ? word[(i % BPW)*W_BITS +: W_BITS] : 8'h00;
        end

        rdQ.delete();
        i_channel     = CH_W'(ch);
        i_num_kernels = N_W'(n);
        i_base_addr   = ADR_W'(base);
        i_start       = 1'b1;
        @(posedge i_clk);
        #1;
        t0 = cyc;
        i_start = 1'b0;
        if (isMiss) begin
            checkOutput("busy_in_fetch", o_busy, 1);
            checkOutput("valid_in_fetch", o_weights_valid, DBUF ? mdlValid : 1'b0);
            checkOutput("weights_in_fetch", countBad(!DBUF), 0);
        end

        waited = 0;
        while (!o_done && !o_err && waited < TIMEOUT) begin
            if (inject && waited == 2) begin
                i_channel = CH_W'(ch + 1);
                i_start   = 1'b1;
            end else begin
                i_channel = CH_W'(ch);
                i_start   = 1'b0;
            end
            @(posedge i_clk);
            #1;
            waited++;
        end
        i_start   = 1'b0;
        i_channel = CH_W'(ch);

        checkOutput("response_timeout", waited < TIMEOUT, 1);
        checkOutput("done_pulse", o_done, !isErr);
        checkOutput("err_pulse", o_err, isErr);
        checkOutput("latency", cyc - t0, isMiss ? wpc + RD_LAT : 0);
        checkOutput("read_count", rdQ.size(), isMiss ? wpc : 0);
        badAddr = 0;
        for (int k = 0; k < rdQ.size() && k < wpc; k++) begin
            if (rdQ[k] !== ADR_W'(first + k)) badAddr++;
        end
        checkOutput("read_addrs", badAddr, 0);

        if (isMiss) begin
            mdlBank  = newBank;
            mdlValid = 1'b1;
            mdlCh    = ch;
            mdlN     = n;
        end
        if (isErr) expErr++; else expDone++;
        checkOutput("busy_after", o_busy, 0);
        checkOutput("valid_after", o_weights_valid, mdlValid);
        checkOutput("weights_after", countBad(1'b0), 0);
    endtask

    initial begin
        int rCh, rN, rBase;
        seed = $urandom;
        mdlValid = 1'b0;
        mdlCh = 0;
        mdlN = 0;
        for (int i = 0; i < NUM_W; i++) mdlBank[i] = 8'h00;
        i_rst = 1'b1;
        i_start = 1'b0;
        i_channel = '0;
        i_num_kernels = '0;
        i_base_addr = '0;
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("reset_busy", o_busy, 0);
        checkOutput("reset_done", o_done, 0);
        checkOutput("reset_err", o_err, 0);
        checkOutput("reset_rden", o_sram_rden, 0);
        checkOutput("reset_addr", o_sram_addr, 0);
        checkOutput("reset_valid", o_weights_valid, 0);
        checkOutput("reset_weights", countBad(1'b1), 0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        applyStimulus(0, 4, 0, 1'b0);
        applyStimulus(0, 4, 0, 1'b0);
        applyStimulus(0, 0, 0, 1'b0);
        applyStimulus(1, 33, 0, 1'b0);
        applyStimulus(2, 32, 16'h0100, 1'b1);
        applyStimulus(5, 1, 16'hFFF0, 1'b0);
        applyStimulus(5, 1, 16'h1234, 1'b0);

        i_channel = 7'd3;
        i_num_kernels = 6'd20;
        i_base_addr = 16'h0040;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("rden_before_abort", o_sram_rden, 1);
        i_rst = 1'b1;
        #1;
        checkOutput("abort_rden", o_sram_rden, 0);
        checkOutput("abort_valid", o_weights_valid, 0);
        checkOutput("abort_busy", o_busy, 0);
        checkOutput("abort_weights", countBad(1'b1), 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        mdlValid = 1'b0;
        for (int i = 0; i < NUM_W; i++) mdlBank[i] = 8'h00;
        repeat (10) @(posedge i_clk);
        #1;
        checkOutput("abort_no_done", doneCnt, expDone);
        applyStimulus(3, 20, 16'h0040, 1'b0);

        rCh = 3;
        rN = 20;
        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 2) != 0) begin
                rCh = $urandom_range(0, 5);
                rN  = $urandom_range(0, MAX_KERNELS + 2);
            end
            rBase = $urandom_range(0, 65535);
            applyStimulus(rCh, rN, rBase, r[0]);
        end

        repeat (5) @(posedge i_clk);
        #1;
        checkOutput("total_done_pulses", doneCnt, expDone);
        checkOutput("total_err_pulses", errCnt, expErr);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
